dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/dmem_arb_pick.sv | 23 ++
 rtl/dmem_arbiter.sv | 116 +++++++++++
 tb/tb_dmem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and
// the owner identifiers used for the grant and round-robin history.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_t;

    localparam logic OWNER_CPU  = 1'b0;
    localparam logic OWNER_HOST = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection between the CPU and host-loader ports.
// On a tie the port that did not win last time is chosen; a caller that
// wants fixed priority simply ties last_owner to OWNER_HOST.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic c_req,
    input  logic h_req,
    input  logic last_owner,
    output logic winner
);

    // Lone requester wins outright; a tie goes to the other-than-last port.
    always_comb begin
        winner = OWNER_CPU;
        if (c_req && h_req) begin
            winner = ~last_owner;
        end else if (h_req) begin
            winner = OWNER_HOST;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a synchronous data memory.
// One access takes IDLE -> ISSUE -> RESP; done is registered on leaving
// RESP, so it is visible during the following IDLE cycle, in which the
// requester may drop or keep req for its next access.
// Optional macro DMEM_ARB_RR_EN: round-robin tie-break via a last_owner
// register; without it the CPU always wins ties.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_done,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_done,
    output logic [DATA_W-1:0] h_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    arb_state_t r_state;
    logic       r_owner;
    logic       r_we;
    logic       w_winner;
    logic       w_last_owner;
    logic       w_any_req;

    assign w_any_req = c_req | h_req;

`ifdef DMEM_ARB_RR_EN
    logic r_last_owner;
    assign w_last_owner = r_last_owner;

    // Grant history: HOST after reset so the first tie goes to the CPU.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_owner <= OWNER_HOST;
        end else if (r_state == ST_IDLE && w_any_req) begin
            r_last_owner <= w_winner;
        end
    end
`else
    // Fixed history of HOST makes every tie resolve to the CPU.
    assign w_last_owner = OWNER_HOST;
`endif

    dmem_arb_pick u_pick (
        .c_req      (c_req),
        .h_req      (h_req),
        .last_owner (w_last_owner),
        .winner     (w_winner)
    );

    // Access FSM; all memory-side and response outputs are registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWNER_CPU;
            r_we        <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            c_done      <= 1'b0;
            h_done      <= 1'b0;
            c_rdata     <= '0;
            h_rdata     <= '0;
        end else begin
            mem_wren <= 1'b0;
            c_done   <= 1'b0;
            h_done   <= 1'b0;
            c_rdata  <= '0;
            h_rdata  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner     <= w_winner;
                        r_we        <= (w_winner == OWNER_HOST) ? h_we    : c_we;
                        mem_address <= (w_winner == OWNER_HOST) ? h_addr  : c_addr;
                        mem_data    <= (w_winner == OWNER_HOST) ? h_wdata : c_wdata;
                        mem_wren    <= (w_winner == OWNER_HOST) ? h_we    : c_we;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Memory samples the address at the end of this cycle.
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    // mem_q now holds the word read in ISSUE.
                    r_state <= ST_IDLE;
                    if (r_owner == OWNER_HOST) begin
                        h_done <= 1'b1;
                        if (!r_we) h_rdata <= mem_q;
                    end else begin
                        c_done <= 1'b1;
                        if (!r_we) c_rdata <= mem_q;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous memory model.
module tb_dmem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          c_req = 1'b0, c_we = 1'b0, h_req = 1'b0, h_we = 1'b0;
    logic [AW-1:0] c_addr = '0, h_addr = '0;
    logic [DW-1:0] c_wdata = '0, h_wdata = '0;
    logic          c_done, h_done, mem_wren;
    logic [DW-1:0] c_rdata, h_rdata, mem_data;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_q = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] dmem [0:(1<<AW)-1];
    logic          pl_we = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always #5 clock = ~clock;

    // Synchronous memory with a bench preload port.
    always @(posedge clock) begin
        if (pl_we) dmem[pl_addr] <= pl_data;
        else if (mem_wren) dmem[mem_address] <= mem_data;
        mem_q <= dmem[mem_address];
    end

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_done(c_done), .c_rdata(c_rdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_done(h_done), .h_rdata(h_rdata),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_addr = a;
        pl_data = d;
        pl_we   = 1'b1;
        tick();
        pl_we   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({mem_wren, mem_address, mem_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_mem: got wren=%b addr=%h data=%h want 0", mem_wren, mem_address, mem_data);
        end
        n_checks++;
        if ({c_done, h_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_done: got %b want 00", {c_done, h_done});
        end
        n_checks++;
        if ({c_rdata, h_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h/%h want 0", c_rdata, h_rdata);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cpu_read();
        preload(12'h010, 32'hDEADBEEF);
        c_req = 1'b1; c_we = 1'b0; c_addr = 12'h010;
        tick();
        n_checks++;
        if (mem_address !== 12'h010 || mem_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_rd_issue: got addr=%h wren=%b want 010/0", mem_address, mem_wren);
        end
        tick();
        n_checks++;
        if (c_done !== 1'b0 || h_done !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_rd_early_done: got %b%b want 00", c_done, h_done);
        end
        tick();
        n_checks++;
        if (c_done !== 1'b1 || c_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL cpu_rd_done: got done=%b rdata=%h want 1/deadbeef", c_done, c_rdata);
        end
        n_checks++;
        if (h_done !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_rd_hdone: got %b want 0", h_done);
        end
        c_req = 1'b0;
        tick();
        n_checks++;
        if (c_done !== 1'b0 || c_rdata !== '0) begin
            n_fail++;
            $display("FAIL cpu_rd_pulse: got done=%b rdata=%h want 0/0", c_done, c_rdata);
        end
    endtask

    task automatic test_host_write();
        h_req = 1'b1; h_we = 1'b1; h_addr = 12'hFFF; h_wdata = 32'h12345678;
        tick();
        n_checks++;
        if (mem_wren !== 1'b1 || mem_address !== 12'hFFF || mem_data !== 32'h12345678) begin
            n_fail++;
            $display("FAIL h_wr_issue: got wren=%b addr=%h data=%h want 1/fff/12345678", mem_wren, mem_address, mem_data);
        end
        tick();
        n_checks++;
        if (mem_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL h_wr_wren_len: got %b want 0", mem_wren);
        end
        tick();
        n_checks++;
        if (h_done !== 1'b1 || h_rdata !== '0 || c_done !== 1'b0) begin
            n_fail++;
            $display("FAIL h_wr_done: got hdone=%b hrdata=%h cdone=%b want 1/0/0", h_done, h_rdata, c_done);
        end
        h_req = 1'b0; h_we = 1'b0;
        tick();
        c_req = 1'b1; c_we = 1'b0; c_addr = 12'hFFF;
        tick(); tick(); tick();
        n_checks++;
        if (c_done !== 1'b1 || c_rdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL wrap_readback: got done=%b rdata=%h want 1/12345678", c_done, c_rdata);
        end
        c_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_abort();
        int ndone;
        preload(12'h005, 32'h00000055);
        c_req = 1'b1; c_we = 1'b1; c_addr = 12'h005; c_wdata = 32'h000000AA;
        tick();
        n_checks++;
        if (mem_wren !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_issue: got wren=%b want 1", mem_wren);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (mem_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_wren: got %b want 0", mem_wren);
        end
        c_req = 1'b0; c_we = 1'b0;
        #1 reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            ndone += int'(c_done) + int'(h_done);
        end
        n_checks++;
        if (ndone != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d pulses want 0", ndone);
        end
        c_req = 1'b1; c_addr = 12'h005;
        tick(); tick(); tick();
        n_checks++;
        if (c_done !== 1'b1 || c_rdata !== 32'h00000055) begin
            n_fail++;
            $display("FAIL abort_next: got done=%b rdata=%h want 1/00000055", c_done, c_rdata);
        end
        c_req = 1'b0;
        tick();
    endtask

    task automatic test_arbitration();
        int   c_rem, h_rem, ng, nboth;
        logic g   [4];
        logic exp [4];
`ifdef DMEM_ARB_RR_EN
        exp = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp = '{1'b0, 1'b0, 1'b1, 1'b1};
`endif
        do_reset();
        c_rem = 2; h_rem = 2; ng = 0; nboth = 0;
        g = '{1'b0, 1'b0, 1'b0, 1'b0};
        c_we = 1'b0; h_we = 1'b0; c_addr = 12'h010; h_addr = 12'hFFF;
        c_req = 1'b1; h_req = 1'b1;
        for (int cyc = 0; cyc < 60 && ng < 4; cyc++) begin
            tick();
            if (c_done && h_done) nboth++;
            if (c_done) begin g[ng] = 1'b0; ng++; c_rem--; end
            else if (h_done) begin g[ng] = 1'b1; ng++; h_rem--; end
            c_req = (c_rem > 0);
            h_req = (h_rem > 0);
        end
        c_req = 1'b0; h_req = 1'b0;
        n_checks++;
        if (ng != 4) begin
            n_fail++;
            $display("FAIL arb_count: got %0d grants want 4", ng);
        end
        n_checks++;
        if (nboth != 0) begin
            n_fail++;
            $display("FAIL arb_both_done: got %0d overlaps want 0", nboth);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (g[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL arb_order[%0d]: got %s want %s", i, g[i] ? "H" : "C", exp[i] ? "H" : "C");
            end
        end
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        logic want;
        preload(12'h020, 32'h00000011);
        c_req = 1'b1; c_we = 1'b0; c_addr = 12'h020;
        for (int k = 0; k < 9; k++) begin
            tick();
            want = ((k % 3) == 2);
            n_checks++;
            if (c_done !== want || h_done !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_done[%0d]: got c=%b h=%b want c=%b h=0", k, c_done, h_done, want);
            end
            if (want) begin
                n_checks++;
                if (c_rdata !== 32'h00000011) begin
                    n_fail++;
                    $display("FAIL b2b_rdata[%0d]: got %h want 00000011", k, c_rdata);
                end
            end
        end
        c_req = 1'b0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_host_write();
        test_reset_abort();
        test_arbitration();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
